// File: rtl/mem_issue_queue.sv
// mem_issue_queue: load/store reservation station with tag wakeup, oldest-first issue and mispredict squash
module mem_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int ROB_DEPTH = 16,
  parameter int PREG_W    = 7,
  parameter int ROB_W     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                disp_valid,
  output logic                disp_ready,
  input  logic [6:0]          disp_opcode,
  input  logic [2:0]          disp_func3,
  input  logic [31:0]         disp_imm,
  input  logic [PREG_W-1:0]   disp_pd,
  input  logic [PREG_W-1:0]   disp_ps1,
  input  logic [PREG_W-1:0]   disp_ps2,
  input  logic                disp_ps1_rdy,
  input  logic                disp_ps2_rdy,
  input  logic [ROB_W-1:0]    disp_rob,
  input  logic [1:0]          wk_valid,
  input  logic [2*PREG_W-1:0] wk_pd,
  input  logic                fu_ready,
  output logic                issued,
  output logic [6:0]          iss_opcode,
  output logic [2:0]          iss_func3,
  output logic [31:0]         iss_imm,
  output logic [PREG_W-1:0]   iss_pd,
  output logic [PREG_W-1:0]   iss_ps1,
  output logic [PREG_W-1:0]   iss_ps2,
  output logic [ROB_W-1:0]    iss_rob,
  input  logic [ROB_W-1:0]    rob_head,
  input  logic                mispredict,
  input  logic [ROB_W-1:0]    mispredict_tag,
  output logic [3:0]          count
);
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]  v_q, v_d, st_q, r1_q, r2_q, r1_d, r2_d, elig, blk;
  logic [2:0]        f3_q  [DEPTH];
  logic [31:0]       imm_q [DEPTH];
  logic [PREG_W-1:0] pd_q  [DEPTH];
  logic [PREG_W-1:0] ps1_q [DEPTH];
  logic [PREG_W-1:0] ps2_q [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH];
  logic [ROB_W-1:0]  age   [DEPTH];
  logic [ROB_W-1:0]  best_age, misp_age;
  logic [IW-1:0]     sel, free;
  logic              found, disp_ld, disp_st, accept;
  logic [3:0]        count_q, count_d;

  function automatic logic [ROB_W-1:0] age_of(input logic [ROB_W-1:0] t, input logic [ROB_W-1:0] h);
    return t >= h ? t - h : t + ROB_W'(ROB_DEPTH) - h;
  endfunction

  function automatic logic hit(input logic [PREG_W-1:0] p, input logic [1:0] v, input logic [2*PREG_W-1:0] t);
    return (v[0] && t[0 +: PREG_W] == p) || (v[1] && t[PREG_W +: PREG_W] == p);
  endfunction

  assign disp_ld    = disp_opcode == OP_LD;
  assign disp_st    = disp_opcode == OP_ST;
  assign disp_ready = count_q < 4'(DEPTH);
  assign accept     = disp_valid && disp_ready && !mispredict && (disp_ld || disp_st);
  assign misp_age   = age_of(mispredict_tag, rob_head);
  assign count      = count_q;

  // A load waits behind every older store still in the queue, ready or not.
  always_comb begin
    blk      = '0;
    elig     = '0;
    sel      = '0;
    free     = '0;
    found    = 1'b0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) age[i] = age_of(rob_q[i], rob_head);
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (v_q[j] && st_q[j] && age[j] < age[i]) blk[i] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = v_q[i] && r1_q[i] && r2_q[i] && (st_q[i] || !blk[i]);
      if (elig[i] && (!found || age[i] < best_age)) begin
        found    = 1'b1;
        best_age = age[i];
        sel      = IW'(i);
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) if (!v_q[i]) free = IW'(i);
  end

  assign issued     = fu_ready && found && !mispredict;
  assign iss_opcode = issued ? (st_q[sel] ? OP_ST : OP_LD) : '0;
  assign iss_func3  = issued ? f3_q[sel]  : '0;
  assign iss_imm    = issued ? imm_q[sel] : '0;
  assign iss_pd     = issued ? pd_q[sel]  : '0;
  assign iss_ps1    = issued ? ps1_q[sel] : '0;
  assign iss_ps2    = issued ? ps2_q[sel] : '0;
  assign iss_rob    = issued ? rob_q[sel] : '0;

  always_comb begin
    v_d     = '0;
    r1_d    = '0;
    r2_d    = '0;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_d[i]  = (v_q[i] && !(issued && sel == IW'(i)) && !(mispredict && age[i] > misp_age))
                || (accept && free == IW'(i));
      r1_d[i] = (accept && free == IW'(i)) ? disp_ps1_rdy || hit(disp_ps1, wk_valid, wk_pd)
                                           : r1_q[i] || hit(ps1_q[i], wk_valid, wk_pd);
      r2_d[i] = (accept && free == IW'(i)) ? disp_ld || disp_ps2_rdy || hit(disp_ps2, wk_valid, wk_pd)
                                           : r2_q[i] || hit(ps2_q[i], wk_valid, wk_pd);
      count_d = count_d + 4'(v_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
    end
  end

  // Payload and readiness only matter while the entry is valid, so they carry no reset.
  always_ff @(posedge clk) begin
    r1_q <= r1_d;
    r2_q <= r2_d;
    for (int i = 0; i < DEPTH; i++)
      if (accept && free == IW'(i)) begin
        st_q[i]  <= disp_st;
        f3_q[i]  <= disp_func3;
        imm_q[i] <= disp_imm;
        pd_q[i]  <= disp_pd;
        ps1_q[i] <= disp_ps1;
        ps2_q[i] <= disp_ps2;
        rob_q[i] <= disp_rob;
      end
  end
endmodule

// File: tb/tb_mem_issue_queue.sv
// tb_mem_issue_queue: directed table vectors plus hand sequences for full, mispredict and reset cases
module tb_mem_issue_queue;
  localparam logic [6:0] L = 7'b0000011;
  localparam logic [6:0] S = 7'b0100011;

  logic        clk = 1'b0, reset = 1'b1;
  logic        disp_valid, disp_ready, disp_ps1_rdy, disp_ps2_rdy, fu_ready, issued, mispredict;
  logic [6:0]  disp_opcode, disp_pd, disp_ps1, disp_ps2, iss_opcode, iss_pd, iss_ps1, iss_ps2;
  logic [2:0]  disp_func3, iss_func3;
  logic [31:0] disp_imm, iss_imm;
  logic [4:0]  disp_rob, iss_rob, rob_head, mispredict_tag;
  logic [1:0]  wk_valid;
  logic [13:0] wk_pd;
  logic [3:0]  count;
  int n_chk = 0, n_fail = 0;

  mem_issue_queue dut (
    .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_func3(disp_func3), .disp_imm(disp_imm), .disp_pd(disp_pd),
    .disp_ps1(disp_ps1), .disp_ps2(disp_ps2), .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
    .disp_rob(disp_rob), .wk_valid(wk_valid), .wk_pd(wk_pd), .fu_ready(fu_ready), .issued(issued),
    .iss_opcode(iss_opcode), .iss_func3(iss_func3), .iss_imm(iss_imm), .iss_pd(iss_pd),
    .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_rob(iss_rob), .rob_head(rob_head),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dv; logic [6:0] op; logic [4:0] rob; logic [6:0] ps1; logic r1; logic [6:0] ps2; logic r2;
    logic [31:0] imm; logic [4:0] head; logic [1:0] wkv; logic [13:0] wkp; logic fu;
    logic e_iss; logic [4:0] e_rob; logic [31:0] e_imm; logic [3:0] e_cnt; logic [6:0] e_op;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(logic dv, logic [6:0] op, logic [4:0] rob, logic [6:0] ps1, logic r1,
                              logic [6:0] ps2, logic r2, logic [31:0] imm, logic [4:0] head,
                              logic [1:0] wkv, logic [13:0] wkp, logic fu, logic e_iss,
                              logic [4:0] e_rob, logic [31:0] e_imm, logic [3:0] e_cnt, logic [6:0] e_op);
    vec_t v;
    v.dv = dv; v.op = op; v.rob = rob; v.ps1 = ps1; v.r1 = r1; v.ps2 = ps2; v.r2 = r2; v.imm = imm;
    v.head = head; v.wkv = wkv; v.wkp = wkp; v.fu = fu;
    v.e_iss = e_iss; v.e_rob = e_rob; v.e_imm = e_imm; v.e_cnt = e_cnt; v.e_op = e_op;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    disp_valid = 0; disp_opcode = L; disp_func3 = 3'd2; disp_imm = 0; disp_pd = 7'd1;
    disp_ps1 = 0; disp_ps2 = 0; disp_ps1_rdy = 1; disp_ps2_rdy = 1; disp_rob = 0;
    wk_valid = 0; wk_pd = 0; fu_ready = 1; rob_head = 0; mispredict = 0; mispredict_tag = 0;
  endtask

  task automatic disp(logic [6:0] op, logic [4:0] rob, logic [6:0] ps1, logic r1);
    disp_valid = 1; disp_opcode = op; disp_rob = rob; disp_ps1 = ps1; disp_ps1_rdy = r1;
    disp_ps2 = 0; disp_ps2_rdy = 1; disp_imm = 32'(rob) * 4;
  endtask

  task automatic pulse_reset();
    reset = 1; @(negedge clk); reset = 0; idle();
  endtask

  initial begin
    idle();
    vq.push_back(mk(1, L, 3, 10, 1, 0, 1, 8, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 8, 1, L));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, S, 4, 1, 1, 12, 0, 16, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, L, 5, 2, 1, 0, 0, 20, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 0, 2'b01, 14'd12, 1, 0, 0, 0, 2, 0));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 16, 2, S));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 20, 1, L));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, L, 2, 3, 1, 0, 0, 36, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, L, 1, 4, 1, 0, 0, 44, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 44, 2, L));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 36, 1, L));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 7'b0110011, 6, 5, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, L, 7, 20, 0, 0, 0, 28, 0, 2'b10, {7'd20, 7'd0}, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 28, 1, L));
    vq.push_back(mk(0, L, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    @(negedge clk); @(negedge clk);
    chk("reset_issued", issued, 0);
    chk("reset_count", count, 0);
    chk("reset_ready", disp_ready, 1);
    chk("reset_iss_rob", iss_rob, 0);
    reset = 0;

    foreach (vq[k]) begin
      disp_valid = vq[k].dv; disp_opcode = vq[k].op; disp_rob = vq[k].rob; disp_ps1 = vq[k].ps1;
      disp_ps1_rdy = vq[k].r1; disp_ps2 = vq[k].ps2; disp_ps2_rdy = vq[k].r2; disp_imm = vq[k].imm;
      rob_head = vq[k].head; wk_valid = vq[k].wkv; wk_pd = vq[k].wkp; fu_ready = vq[k].fu;
      #2;
      chk($sformatf("v%0d_issued", k), issued, vq[k].e_iss);
      chk($sformatf("v%0d_rob", k), iss_rob, vq[k].e_rob);
      chk($sformatf("v%0d_imm", k), iss_imm, vq[k].e_imm);
      chk($sformatf("v%0d_op", k), iss_opcode, vq[k].e_op);
      chk($sformatf("v%0d_count", k), count, vq[k].e_cnt);
      chk($sformatf("v%0d_ready", k), disp_ready, 1);
      @(negedge clk);
    end

    // fill to capacity, wake one entry and watch the slot reopen a cycle after its issue
    idle();
    for (int i = 0; i < 8; i++) begin
      disp(L, 5'(i), 7'(30 + i), 0);
      #2 chk("fill_ready", disp_ready, 1);
      @(negedge clk);
    end
    disp(L, 8, 50, 1);
    #2 chk("full_count", count, 8);
    chk("full_ready", disp_ready, 0);
    chk("full_issued", issued, 0);
    @(negedge clk);
    idle(); wk_valid = 2'b01; wk_pd = {7'd0, 7'd30};
    #2 chk("full_hold_count", count, 8);
    @(negedge clk);
    idle(); disp(L, 8, 50, 1);
    #2 chk("full_iss", issued, 1);
    chk("full_iss_rob", iss_rob, 0);
    chk("full_iss_ready", disp_ready, 0);
    @(negedge clk);
    idle();
    #2 chk("freed_count", count, 7);
    chk("freed_ready", disp_ready, 1);
    chk("freed_issued", issued, 0);
    @(negedge clk);
    pulse_reset();

    // squash across the ROB wrap point
    rob_head = 14;
    for (int i = 0; i < 4; i++) begin
      disp(L, 5'((14 + i) % 16), 7'(40 + i), 0);
      rob_head = 14;
      @(negedge clk);
    end
    idle(); rob_head = 14; mispredict = 1; mispredict_tag = 15;
    wk_valid = 2'b01; wk_pd = {7'd0, 7'd40};
    disp(L, 2, 60, 1);
    #2 chk("misp_issued", issued, 0);
    chk("misp_count_before", count, 4);
    @(negedge clk);
    idle(); rob_head = 14;
    #2 chk("misp_count", count, 2);
    chk("misp_survivor_iss", issued, 1);
    chk("misp_survivor_rob", iss_rob, 14);
    @(negedge clk);
    #2 chk("misp_count_after", count, 1);
    chk("misp_rob15_wait", issued, 0);
    @(negedge clk);
    pulse_reset();

    // issue plus dispatch keeps count, then asynchronous reset mid-cycle
    fu_ready = 0;
    for (int i = 0; i < 3; i++) begin
      disp(L, 5'(i), 7'(70 + i), 1);
      fu_ready = 0;
      @(negedge clk);
    end
    disp(L, 3, 73, 1); fu_ready = 1;
    #2 chk("rst_pre_iss", issued, 1);
    chk("rst_pre_rob", iss_rob, 0);
    chk("rst_pre_count", count, 3);
    @(negedge clk);
    idle();
    #2 chk("rst_swap_count", count, 3);
    chk("rst_swap_iss", issued, 1);
    #1 reset = 1;
    #1 chk("rst_async_issued", issued, 0);
    chk("rst_async_count", count, 0);
    chk("rst_async_ready", disp_ready, 1);
    chk("rst_async_rob", iss_rob, 0);
    chk("rst_async_imm", iss_imm, 0);
    @(negedge clk);
    reset = 0;
    #2 chk("rst_after_issued", issued, 0);
    chk("rst_after_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
